// File: rtl/dcs_pkg.sv
// Shared types, width helpers and default parameters for the DCS attention engine.
//   state_e : engine sequencing states
//   aw()    : Gram accumulator width for DW-bit elements over D columns
//   sw()    : row-sum width (accumulator width plus log2 of the row count)
package dcs_pkg;

  localparam int unsigned N_DEF  = 8;
  localparam int unsigned D_DEF  = 16;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned OW_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MEAN,
    S_THRESH,
    S_WEIGHT,
    S_DRAIN,
    S_OUT
  } state_e;

  function automatic int unsigned aw(input int unsigned dw, input int unsigned d);
    return 2 * dw + 32'($clog2(d));
  endfunction

  function automatic int unsigned sw(input int unsigned dw, input int unsigned d,
                                     input int unsigned n);
    return aw(dw, d) + 32'($clog2(n));
  endfunction

endpackage

// File: rtl/dcs_gram_mac.sv
// N-wide multiplier bank with accumulator write-back.
//   scalar_i : element broadcast to every lane
//   vec_i    : per-lane multiplicand
//   acc_i    : per-lane accumulator value to add the product to
//   prod_c_o : per-lane product (combinational)
//   sum_c_o  : per-lane acc_i + product, truncated to the accumulator width (combinational)
module dcs_gram_mac
  import dcs_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = aw(DW_DEF, D_DEF)
) (
  input  logic [DW-1:0]           scalar_i,
  input  logic [N-1:0][AW-1:0]    vec_i,
  input  logic [N-1:0][AW-1:0]    acc_i,
  output logic [N-1:0][AW+DW-1:0] prod_c_o,
  output logic [N-1:0][AW-1:0]    sum_c_o
);

  localparam int unsigned PW = AW + DW;

  always_comb begin
    for (int j = 0; j < int'(N); j++) begin
      prod_c_o[j] = PW'(scalar_i) * PW'(vec_i[j]);
      sum_c_o[j]  = acc_i[j] + AW'(prod_c_o[j]);
    end
  end

endmodule

// File: rtl/dcs_attn_engine.sv
// Streaming attention-score engine: accumulates A = I*I^T from a row-major
// N x D stream, zeroes entries not strictly above their row mean, multiplies
// by a streamed N-entry weight vector and emits y[0..N-1] with backpressure.
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_valid/i_data/i_ready : I element stream (accepted only while loading)
//   w_valid/w_data/w_ready : weight stream (accepted only in the weight phase)
//   o_valid/o_data/o_ready : result stream, y zero-extended to OW
// Build option: DCS_SOFT_THRESH_EN makes kept entries A - mean instead of A.
module dcs_attn_engine
  import dcs_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned D  = D_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned OW = OW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          i_ready,
  input  logic          w_valid,
  input  logic [DW-1:0] w_data,
  output logic          w_ready,
  output logic          o_valid,
  output logic [OW-1:0] o_data,
  input  logic          o_ready
);

  localparam int unsigned AW = aw(DW, D);
  localparam int unsigned SW = sw(DW, D, N);
  localparam int unsigned NW = $clog2(N);
  localparam int unsigned CW = $clog2(D);
  localparam int unsigned PW = AW + DW;
  localparam int unsigned YW = PW + NW;

  if (YW > OW) begin : g_ow_check
    $error("dcs_attn_engine: OW too narrow for AW+DW+log2(N)");
  end

  state_e        state_q, state_d;
  logic          i_ready_q, i_ready_d, w_ready_q, w_ready_d, o_valid_q, o_valid_d;
  logic [OW-1:0] o_data_q, o_data_d;
  logic [NW-1:0] row_q, row_d, idx_q, idx_d;
  logic [CW-1:0] col_q, col_d;
  logic          ld_xfer, w_xfer, o_xfer, mean_en, thr_en, clr;

  logic [DW-1:0] x_q;
  logic [NW-1:0] xr_q;
  logic [CW-1:0] xc_q;
  logic          xv_q, pv_q;
  logic [DW-1:0] ibuf_q [N][D];
  logic [AW-1:0] a_q    [N][N];
  logic [AW-1:0] mean_q [N];
  logic [PW-1:0] p_q    [N];
  logic [YW-1:0] y_q    [N];
  logic [YW-1:0] y_d    [N];
  logic [AW-1:0] thr_val [N];
  logic [SW-1:0] row_sum;

  logic [DW-1:0]        mac_scalar;
  logic [N-1:0][AW-1:0] mac_vec, mac_acc, mac_sum;
  logic [N-1:0][PW-1:0] mac_prod;

  assign ld_xfer = (state_q == S_LOAD) && i_valid && i_ready_q;
  assign w_xfer  = (state_q == S_WEIGHT) && w_valid && w_ready_q;
  assign o_xfer  = o_valid_q && o_ready;

  assign i_ready = i_ready_q;
  assign w_ready = w_ready_q;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;

  // Lane operands: Gram update while loading, weight products in the weight phase.
  always_comb begin
    mac_scalar = (state_q == S_WEIGHT) ? w_data : x_q;
    for (int j = 0; j < int'(N); j++) begin
      mac_vec[j] = (state_q == S_WEIGHT) ? a_q[j][idx_q] : AW'(ibuf_q[j][xc_q]);
      // A is symmetric during load, so row xr_q also serves as column xr_q.
      mac_acc[j] = a_q[xr_q][j];
    end
  end

  dcs_gram_mac #(.N(N), .DW(DW), .AW(AW)) u_mac (
    .scalar_i (mac_scalar),
    .vec_i    (mac_vec),
    .acc_i    (mac_acc),
    .prod_c_o (mac_prod),
    .sum_c_o  (mac_sum)
  );

  // Row sum for the mean phase and thresholded row for the threshold phase.
  always_comb begin
    row_sum = '0;
    for (int j = 0; j < int'(N); j++) begin
      row_sum = row_sum + SW'(a_q[idx_q][j]);
    end
    for (int c = 0; c < int'(N); c++) begin
      thr_val[c] = '0;
      if (a_q[idx_q][c] > mean_q[idx_q]) begin
`ifdef DCS_SOFT_THRESH_EN
        thr_val[c] = a_q[idx_q][c] - mean_q[idx_q];
`else
        thr_val[c] = a_q[idx_q][c];
`endif
      end
    end
  end

  // Second stage of the weight pipeline: fold the registered products into y.
  always_comb begin
    for (int r = 0; r < int'(N); r++) begin
      y_d[r] = pv_q ? (y_q[r] + YW'(p_q[r])) : y_q[r];
    end
  end

  // Sequencing and handshake outputs.
  always_comb begin
    state_d   = state_q;
    i_ready_d = i_ready_q;
    w_ready_d = w_ready_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    row_d     = row_q;
    col_d     = col_q;
    idx_d     = idx_q;
    mean_en   = 1'b0;
    thr_en    = 1'b0;
    clr       = 1'b0;
    case (state_q)
      S_IDLE: begin
        i_ready_d = 1'b1;
        row_d     = '0;
        col_d     = '0;
        idx_d     = '0;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        // i_ready low here means the last element is in the MAC stage (flush cycle).
        if (!i_ready_q) begin
          state_d = S_MEAN;
          idx_d   = '0;
        end else if (ld_xfer) begin
          if (col_q == CW'(D - 1)) begin
            col_d = '0;
            if (row_q == NW'(N - 1)) i_ready_d = 1'b0;
            else                     row_d = row_q + NW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_MEAN: begin
        mean_en = 1'b1;
        idx_d   = idx_q + NW'(1);
        if (idx_q == NW'(N - 1)) state_d = S_THRESH;
      end
      S_THRESH: begin
        thr_en = 1'b1;
        idx_d  = idx_q + NW'(1);
        if (idx_q == NW'(N - 1)) begin
          w_ready_d = 1'b1;
          state_d   = S_WEIGHT;
        end
      end
      S_WEIGHT: begin
        if (w_xfer) begin
          idx_d = idx_q + NW'(1);
          if (idx_q == NW'(N - 1)) begin
            w_ready_d = 1'b0;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        o_valid_d = 1'b1;
        o_data_d  = OW'(y_d[0]);
        idx_d     = '0;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (o_xfer) begin
          if (idx_q == NW'(N - 1)) begin
            o_valid_d = 1'b0;
            o_data_d  = '0;
            idx_d     = '0;
            clr       = 1'b1;
            state_d   = S_IDLE;
          end else begin
            idx_d    = idx_q + NW'(1);
            o_data_d = OW'(y_q[idx_q + NW'(1)]);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      i_ready_q <= 1'b0;
      w_ready_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      row_q     <= '0;
      col_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      i_ready_q <= i_ready_d;
      w_ready_q <= w_ready_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      row_q     <= row_d;
      col_q     <= col_d;
      idx_q     <= idx_d;
    end
  end

  // Datapath storage: I buffer, Gram matrix, means, product stage and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      xr_q <= '0;
      xc_q <= '0;
      xv_q <= 1'b0;
      pv_q <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        for (int c = 0; c < int'(D); c++) ibuf_q[i][c] <= '0;
        for (int j = 0; j < int'(N); j++) a_q[i][j] <= '0;
        mean_q[i] <= '0;
        p_q[i]    <= '0;
        y_q[i]    <= '0;
      end
    end else if (clr) begin
      x_q  <= '0;
      xr_q <= '0;
      xc_q <= '0;
      xv_q <= 1'b0;
      pv_q <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        for (int c = 0; c < int'(D); c++) ibuf_q[i][c] <= '0;
        for (int j = 0; j < int'(N); j++) a_q[i][j] <= '0;
        mean_q[i] <= '0;
        p_q[i]    <= '0;
        y_q[i]    <= '0;
      end
    end else begin
      xv_q <= ld_xfer;
      pv_q <= w_xfer;
      if (ld_xfer) begin
        ibuf_q[row_q][col_q] <= i_data;
        x_q  <= i_data;
        xr_q <= row_q;
        xc_q <= col_q;
      end
      // Element (r,c) contributes x*I[j][c] to A[r][j] and A[j][r] for all j <= r.
      if (xv_q) begin
        for (int j = 0; j < int'(N); j++) begin
          if (NW'(j) <= xr_q) begin
            a_q[xr_q][j] <= mac_sum[j];
            a_q[j][xr_q] <= mac_sum[j];
          end
        end
      end
      if (mean_en) mean_q[idx_q] <= AW'(row_sum >> NW);
      if (thr_en) begin
        for (int c = 0; c < int'(N); c++) a_q[idx_q][c] <= thr_val[c];
      end
      if (w_xfer) begin
        for (int r = 0; r < int'(N); r++) p_q[r] <= mac_prod[r];
      end
      for (int r = 0; r < int'(N); r++) y_q[r] <= y_d[r];
    end
  end

endmodule

// File: tb/tb_dcs_attn_engine.sv
// Directed, table-driven bench for dcs_attn_engine (N=8, D=16, DW=8, OW=32).
module tb_dcs_attn_engine;

  localparam int N   = 8;
  localparam int D   = 16;
  localparam int TMO = 2000;

  typedef struct packed {
    logic [N*D-1:0][7:0] imat;
    logic [N-1:0][7:0]   w;
    logic [N-1:0][31:0]  yexp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        i_ready;
  logic        w_valid;
  logic [7:0]  w_data;
  logic        w_ready;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_ready;

  int checks;
  int fails;

  vec_t vecs [5];
  int   ex   [5][8];

  dcs_attn_engine #(.N(8), .D(16), .DW(8), .OW(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_ready (i_ready),
    .w_valid (w_valid),
    .w_data  (w_data),
    .w_ready (w_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ready (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    fails++;
    $display("FAIL %s: handshake timeout", nm);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1);
  endtask

  task automatic idle_gap(input int gap_pct);
    int n;
    if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      n = $urandom_range(3, 1);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_i(input logic [7:0] d, input int gap_pct);
    bit ok;
    i_valid = 1'b0;
    idle_gap(gap_pct);
    i_valid = 1'b1;
    i_data  = d;
    ok = 1'b0;
    for (int t = 0; t < TMO && !ok; t++) begin
      @(negedge clk);
      ok = i_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) timeout("i_handshake");
  endtask

  task automatic send_w(input logic [7:0] d, input int gap_pct);
    bit ok;
    w_valid = 1'b0;
    idle_gap(gap_pct);
    w_valid = 1'b1;
    w_data  = d;
    ok = 1'b0;
    for (int t = 0; t < TMO && !ok; t++) begin
      @(negedge clk);
      ok = w_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) timeout("w_handshake");
  endtask

  task automatic collect(input int vi, input bit stall);
    int          k;
    int          t;
    bit          held;
    bit          rdy;
    logic [31:0] hd;
    k = 0;
    t = 0;
    held = 1'b0;
    hd = '0;
    while (k < N && t < TMO) begin
      rdy = stall ? ((t % 2 == 1) && ($urandom_range(3) != 0)) : 1'b1;
      o_ready = rdy;
      @(negedge clk);
      if (held) chk($sformatf("stall_hold v%0d k%0d", vi, k), {o_valid, o_data}, {1'b1, hd});
      if (!o_valid) chk($sformatf("idle_zero v%0d", vi), 64'(o_data), 64'd0);
      if (o_valid && rdy) begin
        chk($sformatf("y[%0d] v%0d", k, vi), 64'(o_data), 64'(ex[vi][k]));
        k++;
      end
      held = o_valid && !rdy;
      hd   = o_data;
      @(posedge clk);
      #1;
      t++;
    end
    i_valid = 1'b0;
    o_ready = 1'b0;
    if (k < N) timeout("o_handshake");
    @(negedge clk);
    chk($sformatf("end_valid v%0d", vi), 64'(o_valid), 64'd0);
    chk($sformatf("end_data v%0d", vi), 64'(o_data), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int vi, input int gap_pct, input bit stall);
    // Weight stream held valid with junk during load: must not be consumed early.
    w_valid = 1'b1;
    w_data  = 8'hEE;
    for (int e = 0; e < N * D; e++) send_i(vecs[vi].imat[e], gap_pct);
    // I stream held valid with junk outside load: must not be consumed.
    i_valid = 1'b1;
    i_data  = 8'h5A;
    for (int k = 0; k < N; k++) send_w(vecs[vi].w[k], gap_pct);
    w_valid = 1'b0;
    collect(vi, stall);
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    w_valid = 1'b0;
    w_data  = '0;
    o_ready = 1'b0;

    // Vector table: inputs plus hand-computed expected y.
    for (int v = 0; v < 5; v++) vecs[v] = '0;
    for (int r = 0; r < N; r++) begin
      vecs[0].imat[r*D] = 8'(r + 1);
      vecs[0].w[r]      = 8'd1;
      for (int c = 0; c < D; c++) vecs[1].imat[r*D+c] = 8'd1;
      vecs[1].w[r]      = 8'd1;
      vecs[2].w[r]      = 8'd255;
      vecs[3].imat[r*D+r] = 8'd1;
      vecs[3].w[r]      = 8'(r + 3);
      vecs[4].imat[r*D] = 8'(r + 1);
      vecs[4].w[r]      = 8'(r);
    end
    for (int c = 0; c < D; c++) vecs[2].imat[c] = 8'd255;
`ifdef DCS_SOFT_THRESH_EN
    ex[0] = '{10, 16, 26, 32, 42, 48, 58, 64};
    ex[2] = '{232139250, 0, 0, 0, 0, 0, 0, 0};
    ex[4] = '{60, 98, 158, 196, 256, 294, 354, 392};
`else
    ex[0] = '{26, 52, 78, 104, 130, 156, 182, 208};
    ex[2] = '{265302000, 0, 0, 0, 0, 0, 0, 0};
    ex[4] = '{148, 296, 444, 592, 740, 888, 1036, 1184};
`endif
    ex[1] = '{0, 0, 0, 0, 0, 0, 0, 0};
    ex[3] = '{3, 4, 5, 6, 7, 8, 9, 10};
    for (int v = 0; v < 5; v++)
      for (int k = 0; k < N; k++) vecs[v].yexp[k] = 32'(ex[v][k]);

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst i_ready", 64'(i_ready), 64'd0);
    chk("rst w_ready", 64'(w_ready), 64'd0);
    chk("rst o_valid", 64'(o_valid), 64'd0);
    chk("rst o_data", 64'(o_data), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table sweep.
    for (int v = 0; v < 5; v++) run_vec(v, 0, 1'b0);

    // Output backpressure: alternate-cycle plus random stalls.
    run_vec(0, 0, 1'b1);

    // Input gaps, then reset pulsed mid-load.
    for (int e = 0; e < 40; e++) send_i(vecs[0].imat[e], 30);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    chk("midrst i_ready", 64'(i_ready), 64'd0);
    chk("midrst w_ready", 64'(w_ready), 64'd0);
    chk("midrst o_valid", 64'(o_valid), 64'd0);
    chk("midrst o_data", 64'(o_data), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst i_ready", 64'(i_ready), 64'd0);
    @(posedge clk);
    #1;
    run_vec(0, 30, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
